// File: rtl/cpeta_err_profiler.sv
// Error profiler for a 16-bit CPETA approximate adder: LFSR operand source, 3-stage compare pipe, error statistics.
// Optional build macro CPETA_PROF_SAT_EN makes sum_ed saturate instead of wrap.

// CPETA: exact upper byte with a 2-bit carry predictor, error-tolerant lower byte
// (from the highest bit where both operands are 1 downward, result bits are forced to 1).
module cpeta (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);
  logic [7:0] w_gen;
  logic [7:0] w_fill;
  logic       w_carry;

  assign w_gen = i_a[7:0] & i_b[7:0];

  // NOTE: every bit of w_fill is assigned on every pass, so no latch is inferred.
  always_comb begin
    w_fill[7] = w_gen[7];
    for (int i = 6; i >= 0; i--) begin
      w_fill[i] = w_fill[i+1] | w_gen[i];
    end
  end

  assign w_carry = w_gen[7] | ((i_a[7] | i_b[7]) & w_gen[6]);
  assign o_sum   = {i_a[15:8] + i_b[15:8] + {7'd0, w_carry},
                    (i_a[7:0] ^ i_b[7:0]) | w_fill};
endmodule

module cpeta_err_profiler #(
  parameter int N     = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_samples,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [15:0]      max_ed
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_issue;

  logic [15:0]      r_m;
  logic [15:0]      r_issued;
  logic [31:0]      r_lfsr;

  logic             r_v1;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic             r_v2;
  logic [N-1:0]     r_approx;
  logic [N-1:0]     r_exact;

  logic             r_done;
  logic [15:0]      r_err_count;
  logic [ACC_W-1:0] r_sum_ed;
  logic [15:0]      r_max_ed;

  logic [N-1:0]     w_approx;
  logic [N-1:0]     w_ed;
  logic [ACC_W-1:0] w_sum_next;
  logic [31:0]      w_lfsr_next;

  cpeta u_cpeta (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_sum (w_approx)
  );

  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);
  assign w_ed        = (r_exact >= r_approx) ? (r_exact - r_approx) : (r_approx - r_exact);

`ifdef CPETA_PROF_SAT_EN
  localparam int EXT_W = ((ACC_W > N) ? ACC_W : N) + 1;
  logic [EXT_W-1:0] w_sum_ext;
  assign w_sum_ext  = EXT_W'(r_sum_ed) + EXT_W'(w_ed);
  // Any bit above ACC_W means the add overflowed; once all-ones, it stays there.
  assign w_sum_next = (|w_sum_ext[EXT_W-1:ACC_W]) ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
  assign w_sum_next = r_sum_ed + ACC_W'(w_ed);
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (num_samples == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (r_issued + 16'd1 == r_m) w_next = S_DRAIN;
      end
      // Leave once the last sample has moved past the compare stage.
      S_DRAIN: if (!r_v1) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_m         <= '0;
      r_issued    <= '0;
      r_lfsr      <= 32'd1;
      r_v1        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_v2        <= 1'b0;
      r_approx    <= '0;
      r_exact     <= '0;
      r_err_count <= '0;
      r_sum_ed    <= '0;
      r_max_ed    <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE) && ((r_state != S_DONE) || w_accept);
      if (w_accept) begin
        r_m         <= num_samples;
        r_lfsr      <= (seed == 32'd0) ? 32'd1 : seed;
        r_issued    <= '0;
        r_v1        <= 1'b0;
        r_v2        <= 1'b0;
        r_err_count <= '0;
        r_sum_ed    <= '0;
        r_max_ed    <= '0;
      end else begin
        r_v1 <= w_issue;
        if (w_issue) begin
          r_a      <= r_lfsr[31:16];
          r_b      <= r_lfsr[15:0];
          r_lfsr   <= w_lfsr_next;
          r_issued <= r_issued + 16'd1;
        end
        r_v2 <= r_v1;
        if (r_v1) begin
          r_approx <= w_approx;
          r_exact  <= r_a + r_b;
        end
        if (r_v2) begin
          if (w_ed != '0) r_err_count <= r_err_count + 16'd1;
          r_sum_ed <= w_sum_next;
          if (w_ed > r_max_ed) r_max_ed <= w_ed;
        end
      end
    end
  end

  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = r_done;
  assign err_count = r_err_count;
  assign sum_ed    = r_sum_ed;
  assign max_ed    = r_max_ed;
endmodule

// File: tb/tb_cpeta_err_profiler.sv
// Self-checking bench for cpeta_err_profiler: random-seeded runs against a behavioural golden model.
module tb_cpeta_err_profiler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic [31:0] seed = '0;

  logic        busy, done, busy16, done16;
  logic [15:0] err_count, max_ed, err16, max16, sum16;
  logic [31:0] sum_ed;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] peek_a, peek_b;

  always #5 clk = ~clk;

  cpeta_err_profiler #(.N(16), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .seed(seed),
    .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed)
  );

  cpeta_err_profiler #(.N(16), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .seed(seed),
    .busy(busy16), .done(done16), .err_count(err16), .sum_ed(sum16), .max_ed(max16)
  );

  // Approximate add from its description: scan the low byte from the top, fill with ones
  // after the first double-one; carry into the high byte predicted from the top two low bits.
  function automatic logic [15:0] cpeta_model(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] lo;
    bit fill = 0;
    int c, hi;
    for (int i = 7; i >= 0; i--) begin
      if (a[i] && b[i]) fill = 1;
      lo[i] = fill ? 1'b1 : (a[i] ^ b[i]);
    end
    c  = ((int'(a) & 'hC0) + (int'(b) & 'hC0)) >= 'h100 ? 1 : 0;
    hi = ((int'(a) >> 8) + (int'(b) >> 8) + c) & 'hFF;
    return {hi[7:0], lo};
  endfunction

  function automatic void golden(input logic [31:0] s, input int m,
                                 output int err, output longint sum, output int mx);
    logic [31:0] l = (s == 0) ? 32'd1 : s;
    int a, b, ex, ap, ed;
    err = 0; sum = 0; mx = 0;
    for (int i = 0; i < m; i++) begin
      a  = int'(l[31:16]);
      b  = int'(l[15:0]);
      ex = (a + b) % 65536;
      ap = int'(cpeta_model(l[31:16], l[15:0]));
      ed = (ex > ap) ? ex - ap : ap - ex;
      if (ed != 0) err++;
      sum += ed;
      if (ed > mx) mx = ed;
      l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
    end
  endfunction

  // kind: 0 none, 1 extra start pulse at evt, 2 rst at evt (returns in evt+1), 3 capture stage-1 pair at evt
  task automatic run(input logic [15:0] m, input logic [31:0] s, input int evt, input int kind,
                     output int done_cyc, output bit busy_ok);
    bit exp_busy;
    num_samples = m;
    seed        = s;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    busy_ok  = 1;
    for (int k = 1; k <= int'(m) + 20; k++) begin
      @(negedge clk);
      if (kind == 2 && k == evt + 1) begin
        rst = 1'b0;
        break;
      end
      exp_busy = (m != 0) && (k <= int'(m) + 2);
      if (busy !== exp_busy) busy_ok = 0;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
      if (kind == 1) start = (k == evt);
      if (kind == 2) rst = (k == evt);
      if (kind == 3 && k == evt) begin
        peek_a = dut.r_a;
        peek_b = dut.r_b;
      end
      @(posedge clk);
    end
  endtask

  task automatic check_stats(input string tag, input int e_err, input longint e_sum, input int e_max);
    n_checks += 3;
    if (err_count !== e_err[15:0]) begin
      n_errors++; $display("FAIL %s err_count: got %0d expected %0d", tag, err_count, e_err);
    end
    if (sum_ed !== e_sum[31:0]) begin
      n_errors++; $display("FAIL %s sum_ed: got %0d expected %0d", tag, sum_ed, e_sum[31:0]);
    end
    if (max_ed !== e_max[15:0]) begin
      n_errors++; $display("FAIL %s max_ed: got %0d expected %0d", tag, max_ed, e_max);
    end
  endtask

  task automatic check_run(input string tag, input int done_cyc, input int e_done, input bit busy_ok);
    n_checks += 2;
    if (done_cyc != e_done) begin
      n_errors++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, e_done);
    end
    if (!busy_ok) begin
      n_errors++; $display("FAIL %s busy_profile: got mismatch expected high for cycles 1..%0d", tag, e_done - 1);
    end
  endtask

  task automatic test_reset;
    bit ok = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || err_count !== 16'd0 || sum_ed !== 32'd0 || max_ed !== 16'd0)
        ok = 0;
    end
    n_checks++;
    if (!ok) begin
      n_errors++; $display("FAIL reset_idle: got nonzero outputs expected all 0 for 20 cycles");
    end
  endtask

  task automatic test_single;
    int dc; bit bo;
    run(16'd1, 32'hAAAA_5555, 0, 0, dc, bo);
    check_run("single", dc, 4, bo);
    check_stats("single", 0, 0, 0);
  endtask

  task automatic test_long_run;
    int dc, e_err, e_max; bit bo; longint e_sum;
    golden(32'hDEAD_BEEF, 1000, e_err, e_sum, e_max);
    run(16'd1000, 32'hDEAD_BEEF, 500, 1, dc, bo);
    check_run("long", dc, 1003, bo);
    check_stats("long", e_err, e_sum, e_max);
  endtask

  task automatic test_zero;
    int dc; bit bo;
    run(16'd0, 32'd0, 0, 0, dc, bo);
    check_run("zero_m", dc, 1, bo);
    check_stats("zero_m", 0, 0, 0);
  endtask

  task automatic test_zero_seed;
    int dc, e_err, e_max; bit bo; longint e_sum;
    golden(32'd1, 64, e_err, e_sum, e_max);
    run(16'd64, 32'd0, 2, 3, dc, bo);
    check_run("zero_seed", dc, 67, bo);
    n_checks++;
    if (peek_a !== 16'h0000 || peek_b !== 16'h0001) begin
      n_errors++; $display("FAIL zero_seed_pair: got %h/%h expected 0000/0001", peek_a, peek_b);
    end
    check_stats("zero_seed", e_err, e_sum, e_max);
  endtask

  task automatic test_reset_midrun;
    int dc, e_err, e_max; bit bo; longint e_sum;
    run(16'd1000, 32'hDEAD_BEEF, 300, 2, dc, bo);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL midrun_rst_ctrl: got busy=%b done=%b expected 0/0", busy, done);
    end
    check_stats("midrun_rst", 0, 0, 0);
    golden(32'hDEAD_BEEF, 1000, e_err, e_sum, e_max);
    run(16'd1000, 32'hDEAD_BEEF, 0, 0, dc, bo);
    check_run("rerun", dc, 1003, bo);
    check_stats("rerun", e_err, e_sum, e_max);
  endtask

  task automatic test_overflow;
    int dc, e_err, e_max; bit bo; longint e_sum; logic [15:0] e16;
    golden(32'h1234_5678, 4096, e_err, e_sum, e_max);
    run(16'd4096, 32'h1234_5678, 0, 0, dc, bo);
    check_run("ovf", dc, 4099, bo);
    n_checks++;
    if (e_sum <= 65535) begin
      n_errors++; $display("FAIL ovf_golden_total: got %0d expected > 65535", e_sum);
    end
`ifdef CPETA_PROF_SAT_EN
    e16 = (e_sum > 65535) ? 16'hFFFF : e_sum[15:0];
`else
    e16 = e_sum[15:0];
`endif
    n_checks += 3;
    if (sum16 !== e16) begin
      n_errors++; $display("FAIL ovf_sum16: got %h expected %h", sum16, e16);
    end
    if (err16 !== e_err[15:0]) begin
      n_errors++; $display("FAIL ovf_err16: got %0d expected %0d", err16, e_err);
    end
    if (max16 !== e_max[15:0]) begin
      n_errors++; $display("FAIL ovf_max16: got %0d expected %0d", max16, e_max);
    end
    check_stats("ovf32", e_err, e_sum, e_max);
  endtask

  initial begin
    test_reset;
    test_single;
    test_long_run;
    test_zero;
    test_zero_seed;
    test_reset_midrun;
    test_overflow;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish within 200000 cycles");
    $fatal(1, "timeout");
  end
endmodule
